// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that shares one registered BUS_SIZE output among CHANNELS requesters.
// Optional burst-lock input is enabled by defining MUX_RR_ARBITER_LOCK_EN.
module mux_rr_arbiter #(
  parameter int CHANNELS = 4,
  parameter int BUS_SIZE = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [CHANNELS-1:0]          req,
  input  logic [CHANNELS*BUS_SIZE-1:0] data_in,
`ifdef MUX_RR_ARBITER_LOCK_EN
  input  logic [CHANNELS-1:0]          lock,
`endif
  output logic [CHANNELS-1:0]          ack,
  output logic [CHANNELS-1:0]          grant,
  output logic [CHANNELS-1:0]          selector,
  output logic [BUS_SIZE-1:0]          data_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy
);

  localparam int IdxW = $clog2(CHANNELS);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       ptr_q, ptr_d;
  logic [CHANNELS-1:0]   ack_q, ack_d;
  logic [CHANNELS-1:0]   grant_q, grant_d;
  logic [CHANNELS-1:0]   selector_q, selector_d;
  logic [BUS_SIZE-1:0]   data_q, data_d;
  logic                  valid_q, valid_d;

  logic [BUS_SIZE-1:0]   chan_word [CHANNELS];
  logic [IdxW-1:0]       win_idx;
  logic [CHANNELS-1:0]   win_onehot;
  logic [IdxW-1:0]       scan_idx;
  int                    scan_int;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_slice
    assign chan_word[i] = data_in[BUS_SIZE*i +: BUS_SIZE];
  end

  // Scan from the farthest offset down so the nearest requester after ptr wins;
  // ptr itself (offset CHANNELS) has the lowest priority.
  always_comb begin
    win_idx  = ptr_q;
    scan_int = 0;
    scan_idx = '0;
    for (int off = CHANNELS; off >= 1; off--) begin
      scan_int = (int'(ptr_q) + off) % CHANNELS;
      scan_idx = IdxW'(scan_int);
      if (req[scan_idx]) begin
        win_idx = scan_idx;
      end
    end
`ifdef MUX_RR_ARBITER_LOCK_EN
    // Burst ownership: a locked, still-requesting last winner keeps the bus.
    if (lock[ptr_q] && req[ptr_q]) begin
      win_idx = ptr_q;
    end
`endif
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    ack_d      = '0;
    grant_d    = grant_q;
    selector_d = selector_q;
    data_d     = data_q;
    valid_d    = valid_q;
    case (state_q)
      StIdle: begin
        if (|req) begin
          state_d                = StBusy;
          ptr_d                  = win_idx;
          grant_d                = win_onehot;
          ack_d                  = win_onehot;
          selector_d             = '0;
          selector_d[IdxW-1:0]   = win_idx;
          data_d                 = chan_word[win_idx];
          valid_d                = 1'b1;
        end
      end
      StBusy: begin
        // Selector intentionally keeps the last winner after hand-off.
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          grant_d = '0;
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      ptr_q      <= IdxW'(CHANNELS - 1);
      ack_q      <= '0;
      grant_q    <= '0;
      selector_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      ack_q      <= ack_d;
      grant_q    <= grant_d;
      selector_q <= selector_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
    end
  end

  assign ack       = ack_q;
  assign grant     = grant_q;
  assign selector  = selector_q;
  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign busy      = (state_q == StBusy);

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one BUS_SIZE-wide output path among CHANNELS requesters.
- Drives the `mux` selector, one transfer at a time, and registers the selected word into an output holding register.
- Uses a valid/ready handshake toward the consumer and a one-cycle ack pulse back to the winning requester.
- Sits between the pipeline/debug-unit sources and a shared sink, such as the UART TX path or a register-file read port.

Parameters:
- CHANNELS, 4, number of requesters; also the width of `selector` (matches the `mux` selector width); must be >= 2.
- BUS_SIZE, 32, data word width per channel.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous reset, active-low.
- req  in  CHANNELS  per-requester request level; held high with stable data until acked.
- data_in  in  CHANNELS*BUS_SIZE  flattened channel data; channel i occupies bits [BUS_SIZE*i +: BUS_SIZE].
- ack  out  CHANNELS  one-hot, one-cycle pulse when channel i's word is captured.
- grant  out  CHANNELS  one-hot owner of the output register; held while busy.
- selector  out  CHANNELS  binary index of the current/last granted channel; feeds the `mux` selector.
- data_out  out  BUS_SIZE  registered captured word.
- out_valid  out  1  data_out valid.
- out_ready  in  1  consumer accepts data_out when out_valid && out_ready.
- busy  out  1  high in BUSY state.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; ack=0, grant=0, selector=0, data_out=0, out_valid=0, busy=0.
  - last-grant pointer = CHANNELS-1, so channel 0 has first priority.
- FSM states: IDLE and BUSY.
- IDLE:
  - If req==0: remain in IDLE, outputs unchanged apart from ack=0.
  - If any req bit is high, on the same rising edge:
    - Winner = first set req bit scanning (ptr+1), (ptr+2), … mod CHANNELS.
    - selector <= winner index; grant <= one-hot(winner).
    - data_out <= data_in[BUS_SIZE*winner +: BUS_SIZE].
    - out_valid <= 1; ack[winner] <= 1 for exactly one cycle.
    - ptr <= winner; state <= BUSY.
- BUSY:
  - data_out, grant, selector held; requests ignored; ack=0.
  - On out_valid && out_ready: out_valid <= 0; grant <= 0; state <= IDLE. selector keeps its last value.
- Latency:
  - req high in IDLE -> data_out/out_valid/ack visible 1 cycle later.
  - Minimum 2 cycles per transfer: one capture cycle, plus one IDLE bubble after the handshake.
- Fairness: a continuously requesting channel waits at most CHANNELS-1 other transfers.
- Requesters must drop req in the cycle after seeing ack, or they are re-arbitrated as a new request.
- Boundaries:
  - All req high → strict rotation 0,1,2,…,CHANNELS-1,0.
  - Single requester → granted every transfer.
  - ptr wraps from CHANNELS-1 to 0.
  - out_ready high while idle is ignored.
  - out_ready held high → handshake on the first BUSY cycle.
- Reset mid-BUSY: captured word is discarded; no ack and no out_valid after reset release until a new arbitration.

Optional Feature:
- Macro: MUX_RR_ARBITER_LOCK_EN.
- Defined:
  - Adds input `lock` [CHANNELS].
  - If lock[ptr] && req[ptr] in IDLE, channel ptr wins again regardless of rotation (burst ownership).
  - Rotation resumes once lock[ptr] drops.
- Undefined: no lock port; pure round-robin as above.

Test Plan (CHANNELS=4, BUS_SIZE=32):
- Reset check: assert reset_n=0 mid-cycle -> all outputs 0 immediately; release with req=0 for 5 cycles -> out_valid stays 0.
- Single request: req=4'b0100, data_in ch2=32'hDEADBEEF -> next cycle selector=2, grant=4'b0100, ack=4'b0100 for 1 cycle, data_out=32'hDEADBEEF, out_valid=1; out_ready=1 -> out_valid=0 the following cycle.
- Rotation: req=4'b1111 held, out_ready=1, random data per channel -> successive selector values 0,1,2,3,0; each data_out equals the matching channel slice; one transfer every 2 cycles.
- Backpressure: out_ready=0 for 6 cycles while req=4'b0011 -> data_out/selector/grant stable, no extra ack; out_ready=1 -> handshake, then next grant goes to the other channel.
- Skip/wrap: after a grant to ch3, req=4'b1010 -> selector=1 (wraps to 0, skips it); next grant selector=3.
- Reset mid-BUSY: out_valid=1, pulse reset_n low -> out_valid=0, grant=0; with req=4'b1111 after release -> first grant selector=0. With MUX_RR_ARBITER_LOCK_EN: lock=4'b0001, req=4'b0011 -> selector 0,0,0; clear lock -> next grant selector=1.
